// File: rtl/serial_addsub_unit_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_unit_if
// Request/result bundle for the bit-serial 8-bit adder/subtractor.
//   start   : operation request (requester -> unit)
//   A, B    : 8-bit operands (requester -> unit)
//   opcode  : 0 = A+B, 1 = A-B (requester -> unit)
//   busy    : unit is running or presenting a result (unit -> requester)
//   done    : one-cycle result-valid pulse (unit -> requester)
//   sum     : 8-bit registered result (unit -> requester)
//   c_out   : carry out of bit 7; for subtract 1 means no borrow
//   over    : signed-overflow flag
// ---------------------------------------------------------------------------
interface serial_addsub_unit_if;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       opcode;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;
    logic       over;

    modport master (
        output start, A, B, opcode,
        input  busy, done, sum, c_out, over
    );

    modport slave (
        input  start, A, B, opcode,
        output busy, done, sum, c_out, over
    );
endinterface

// File: rtl/serial_addsub_unit.sv
// ---------------------------------------------------------------------------
// serial_addsub_unit
// Bit-serial 8-bit adder/subtractor. One full adder processes one bit per
// clock, LSB first. Subtraction is A + ~B + 1: B is inverted on capture and
// the carry flop is preset to the opcode.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_addsub_unit_if (start/A/B/opcode in,
//           busy/done/sum/c_out/over out)
// Timing: start accepted at edge k -> done high in the cycle after edge k+8,
// back in IDLE after edge k+9.
// ---------------------------------------------------------------------------
module serial_addsub_unit (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_addsub_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum_bit} of a one-bit full adder.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        full_add = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

    state_t     state_q, state_d;
    logic [7:0] a_sh_q, a_sh_d;
    logic [7:0] b_sh_q, b_sh_d;
    logic [7:0] res_q, res_d;
    logic       carry_q, carry_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;
    logic       c_out_q, c_out_d;
    logic       over_q, over_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] fa_s;

    // Next-state and datapath logic for the three-state sequencer.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        over_d  = over_q;
        fa_s    = full_add(a_sh_q[0], b_sh_q[0], carry_q);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.A;
                    b_sh_d  = bus.B ^ {8{bus.opcode}};
                    carry_d = bus.opcode;
                    cnt_d   = 3'd0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[7:1]};
                b_sh_d  = {1'b0, b_sh_q[7:1]};
                res_d   = {fa_s[0], res_q[7:1]};
                carry_d = fa_s[1];
                if (cnt_q == 3'd7) begin
                    // carry_q is still the carry into bit 7 here, so it is the
                    // saved value that feeds the overflow XOR.
                    state_d = S_DONE;
                    sum_d   = {fa_s[0], res_q[7:1]};
                    c_out_d = fa_s[1];
                    over_d  = carry_q ^ fa_s[1];
                    cnt_d   = cnt_q;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= 8'h00;
            b_sh_q  <= 8'h00;
            res_q   <= 8'h00;
            carry_q <= 1'b0;
            cnt_q   <= 3'd0;
            sum_q   <= 8'h00;
            c_out_q <= 1'b0;
            over_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            over_q  <= over_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.over  = over_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_unit
// Self-checking bench for serial_addsub_unit. Expected results come from a
// small arithmetic model and are queued when an operation is issued, then
// popped and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_serial_addsub_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_addsub_unit_if bus_if ();

    serial_addsub_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    typedef struct packed {
        logic [7:0] sum;
        logic       c_out;
        logic       over;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference arithmetic: A + (B ^ op) + op, with carry into bit 7 from the low 7 bits.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic op);
        logic [7:0] bx;
        logic [8:0] full;
        logic [7:0] low;
        res_t       r;
        bx      = b ^ {8{op}};
        full    = {1'b0, a} + {1'b0, bx} + {8'd0, op};
        low     = {1'b0, a[6:0]} + {1'b0, bx[6:0]} + {7'd0, op};
        r.sum   = full[7:0];
        r.c_out = full[8];
        r.over  = low[7] ^ full[8];
        return r;
    endfunction

    // Drives a one-cycle start pulse and queues the expected result.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic op);
        @(negedge clk);
        bus_if.A      = a;
        bus_if.B      = b;
        bus_if.opcode = op;
        bus_if.start  = 1'b1;
        exp_q.push_back(model(a, b, op));
        @(posedge clk);
        #1;
        bus_if.start  = 1'b0;
    endtask

    // Waits (bounded) for done; returns negedges counted and how many saw busy.
    task automatic wait_done(output int cyc, output int busy_cyc);
        bit seen;
        seen     = 1'b0;
        cyc      = 0;
        busy_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cyc++;
            if (bus_if.busy) busy_cyc++;
            if (bus_if.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.A      = 8'h00;
        bus_if.B      = 8'h00;
        bus_if.opcode = 1'b0;
        #12;
        n_checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_status: busy/done=%b required 00", {bus_if.busy, bus_if.done});
        end
        n_checks++;
        if ({bus_if.sum, bus_if.c_out, bus_if.over} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_result: sum=%h c_out=%b over=%b required 00/0/0",
                     bus_if.sum, bus_if.c_out, bus_if.over);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one operation and checks latency, busy width and result.
    task automatic test_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic op);
        int   cyc;
        int   bc;
        res_t e;
        res_t got;
        issue(a, b, op);
        wait_done(cyc, bc);
        n_checks++;
        if (cyc != 9) begin
            n_fail++;
            $display("FAIL %s_latency: done at cycle %0d required 9", name, cyc);
        end
        n_checks++;
        if (bc != 9) begin
            n_fail++;
            $display("FAIL %s_busy: busy for %0d cycles required 9", name, bc);
        end
        e   = exp_q.pop_front();
        got = '{bus_if.sum, bus_if.c_out, bus_if.over};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s_result: sum=%h c_out=%b over=%b required %h/%b/%b",
                     name, got.sum, got.c_out, got.over, e.sum, e.c_out, e.over);
        end
        @(negedge clk);
        n_checks++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: done=%b busy=%b required 0/0", name, bus_if.done, bus_if.busy);
        end
    endtask

    task automatic test_add();
        test_op("add_00_7f", 8'h00, 8'h7F, 1'b0);
        test_op("add_30_7f", 8'h30, 8'h7F, 1'b0);
        test_op("add_a8_7f", 8'hA8, 8'h7F, 1'b0);
    endtask

    task automatic test_sub();
        test_op("sub_2a_6b", 8'h2A, 8'h6B, 1'b1);
        test_op("sub_24_ef", 8'h24, 8'hEF, 1'b1);
    endtask

    // A second start and operand changes during RUN must be ignored.
    task automatic test_busy_ignore();
        logic [7:0] prev_sum;
        int         ndone;
        res_t       e;
        res_t       got;
        prev_sum = bus_if.sum;
        ndone    = 0;
        got      = '0;
        issue(8'h50, 8'h7F, 1'b0);
        repeat (3) @(negedge clk);
        bus_if.start  = 1'b1;
        bus_if.A      = 8'hFF;
        bus_if.B      = 8'hFF;
        bus_if.opcode = 1'b1;
        n_checks++;
        if (bus_if.sum !== prev_sum) begin
            n_fail++;
            $display("FAIL busy_sum_hold: sum=%h required %h", bus_if.sum, prev_sum);
        end
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.A     = 8'h00;
        bus_if.B     = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus_if.done) begin
                ndone++;
                got = '{bus_if.sum, bus_if.c_out, bus_if.over};
            end
        end
        n_checks++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL busy_done_count: %0d done pulses required 1", ndone);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL busy_result: sum=%h c_out=%b over=%b required %h/%b/%b",
                     got.sum, got.c_out, got.over, e.sum, e.c_out, e.over);
        end
    endtask

    // Reset mid-RUN aborts without a done pulse; the next operation runs normally.
    task automatic test_reset_abort();
        int ndone;
        ndone = 0;
        issue(8'h12, 8'h34, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if ({bus_if.busy, bus_if.done, bus_if.sum, bus_if.c_out, bus_if.over} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b done=%b sum=%h c_out=%b over=%b required all 0",
                     bus_if.busy, bus_if.done, bus_if.sum, bus_if.c_out, bus_if.over);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_if.done || bus_if.busy) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d active cycles after abort required 0", ndone);
        end
        test_op("after_reset_sub", 8'h00, 8'h7F, 1'b1);
    endtask

    // start held high: one acceptance every 10 cycles, one-cycle done, stable sum.
    task automatic test_back_to_back();
        int         cyc;
        int         bc;
        res_t       e;
        res_t       got;
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        @(negedge clk);
        a  = 8'($urandom_range(255));
        b  = 8'($urandom_range(255));
        op = 1'($urandom_range(1));
        bus_if.A      = a;
        bus_if.B      = b;
        bus_if.opcode = op;
        bus_if.start  = 1'b1;
        exp_q.push_back(model(a, b, op));
        for (int i = 0; i < 4; i++) begin
            wait_done(cyc, bc);
            n_checks++;
            if (cyc < 0 || (i == 0 && cyc != 9) || (i > 0 && cyc + 1 != 10)) begin
                n_fail++;
                $display("FAIL b2b_period_%0d: measured %0d required %0d", i,
                         (i == 0) ? cyc : cyc + 1, (i == 0) ? 9 : 10);
            end
            e   = exp_q.pop_front();
            got = '{bus_if.sum, bus_if.c_out, bus_if.over};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL b2b_result_%0d: sum=%h c_out=%b over=%b required %h/%b/%b",
                         i, got.sum, got.c_out, got.over, e.sum, e.c_out, e.over);
            end
            if (i < 3) begin
                a  = 8'($urandom_range(255));
                b  = 8'($urandom_range(255));
                op = 1'($urandom_range(1));
                bus_if.A      = a;
                bus_if.B      = b;
                bus_if.opcode = op;
                exp_q.push_back(model(a, b, op));
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (bus_if.done !== 1'b0 || bus_if.sum !== e.sum) begin
                n_fail++;
                $display("FAIL b2b_width_%0d: done=%b sum=%h required 0/%h", i, bus_if.done, bus_if.sum, e.sum);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
